// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, defaults and the fetch-to-decode instruction types
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int CODE_ADDR_WIDTH_DEF = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    typedef logic [XLEN-1:0] inst_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        inst_t           inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO of {pc, inst} with flush, push, pop and count
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [2:0]   count
);
    fetch_entry_t mem [0:3];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign head = mem[rd_ptr];

    // storage write; entries need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    // pointers and occupancy; flush and reset win over push and pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + 3'(push) - 3'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, synchronous code-memory requests and an instruction buffer
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          CODE_ADDR_WIDTH = CODE_ADDR_WIDTH_DEF,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter int          BUF_DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_en,
    output logic [CODE_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc
);
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         in_flight;
    logic         pop;
    logic [2:0]   count;
    fetch_entry_t head;
    fetch_entry_t wdata;

    // valid comes only from buffer occupancy; reset masks it while asserted
    assign inst_valid = (count != 3'd0) && !reset;
    assign pop        = inst_valid && inst_ready;
    // a slot freed by this cycle's pop can be refilled by the response to this cycle's request
    assign imem_en    = !reset && ((4'(count) + 4'(in_flight) - 4'(pop)) < 4'(BUF_DEPTH));
    assign imem_addr  = pc[CODE_ADDR_WIDTH+1:2];
    assign inst       = reset ? 32'd0 : head.inst;
    assign inst_pc    = reset ? RESET_PC : head.pc;
    assign wdata      = '{pc: req_pc, inst: imem_rdata};

    // fetch PC and in-flight tracking; a redirect kills the request issued in its own cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            in_flight <= 1'b0;
        end else begin
            in_flight <= imem_en && !redirect_valid;
            if (imem_en) req_pc <= pc;
            pc <= redirect_valid ? (redirect_pc & ~32'h3) : imem_en ? pc + 32'd4 : pc;
        end
    end

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (in_flight),
        .push_data(wdata),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle vectors for fetch_unit with a synchronous memory model
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        imem_en;
    logic [3:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        en;
        logic [3:0]  addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // code memory: word n holds E000_0000 + n, one-cycle read latency
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'hE000_0000 + 32'(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        reset          = v.rst;
        inst_ready     = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        @(negedge clk);
        chk({tag, " imem_en"}, 32'(imem_en), 32'(v.en));
        chk({tag, " inst_valid"}, 32'(inst_valid), 32'(v.vld));
        if (v.en) chk({tag, " imem_addr"}, 32'(imem_addr), 32'(v.addr));
        if (v.vld || v.rst) begin
            chk({tag, " inst"}, inst, v.ins);
            chk({tag, " inst_pc"}, inst_pc, v.pc);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic en, input logic [3:0] addr, input logic vld,
                                input logic [31:0] ins, input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.en = en; v.addr = addr; v.vld = vld; v.ins = ins; v.pc = pc;
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        @(posedge clk);
        #1;
        // reset state
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        // streaming start, first valid two cycles after first request
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 2, 1, 32'hE000_0000, 32'h0));
        // stall: request stops, head holds at pc 4
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hE000_0001, 32'h4));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hE000_0001, 32'h4));
        // release: 4, 8, 12... with no loss or duplication
        vecs.push_back(mk(0, 1, 0, 0, 1, 3, 1, 32'hE000_0001, 32'h4));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4, 1, 32'hE000_0002, 32'h8));
        vecs.push_back(mk(0, 1, 0, 0, 1, 5, 1, 32'hE000_0003, 32'hC));
        vecs.push_back(mk(0, 1, 0, 0, 1, 6, 1, 32'hE000_0004, 32'h10));
        // fill both entries, then redirect to 0x1E
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hE000_0005, 32'h14));
        vecs.push_back(mk(0, 0, 1, 32'h1E, 0, 0, 1, 32'hE000_0005, 32'h14));
        vecs.push_back(mk(0, 1, 0, 0, 1, 7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 9, 1, 32'hE000_0007, 32'h1C));
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

        // redirect to 0 with a handshake of pc 0x20 in the same cycle
        step(mk(0, 1, 1, 32'h0, 1, 10, 1, 32'hE000_0008, 32'h20), "h0");
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0), "h1");
        step(mk(0, 1, 0, 0, 1, 1, 0, 0, 0), "h2");
        step(mk(0, 1, 0, 0, 1, 2, 1, 32'hE000_0000, 32'h0), "h3");
        step(mk(0, 1, 0, 0, 1, 3, 1, 32'hE000_0001, 32'h4), "h4");
        // pc 8 consumed during redirect to 56, then address wrap
        step(mk(0, 1, 1, 32'h38, 1, 4, 1, 32'hE000_0002, 32'h8), "h5");
        step(mk(0, 1, 0, 0, 1, 14, 0, 0, 0), "h6");
        step(mk(0, 1, 0, 0, 1, 15, 0, 0, 0), "h7");
        step(mk(0, 1, 0, 0, 1, 0, 1, 32'hE000_000E, 32'd56), "h8");
        step(mk(0, 1, 0, 0, 1, 1, 1, 32'hE000_000F, 32'd60), "h9");
        step(mk(0, 1, 0, 0, 1, 2, 1, 32'hE000_0000, 32'd64), "h10");
        step(mk(0, 1, 0, 0, 1, 3, 1, 32'hE000_0001, 32'd68), "h11");
        // one-cycle reset mid-stream, restart at RESET_PC
        step(mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0), "r0");
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0), "r1");
        step(mk(0, 1, 0, 0, 1, 1, 0, 0, 0), "r2");
        step(mk(0, 1, 0, 0, 1, 2, 1, 32'hE000_0000, 32'h0), "r3");
        step(mk(0, 1, 0, 0, 1, 3, 1, 32'hE000_0001, 32'h4), "r4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
